// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmit and receive engines.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } tx_state_t;

  // Parity select encoding as carried on ohel.
  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } par_mode_t;

  localparam int DLEN_MIN = 5;
  localparam int K_MIN    = 2;

endpackage

// File: rtl/uart_tx_fifo.sv
// Show-ahead synchronous FIFO; a pop frees a slot for a push in the same cycle.
module uart_tx_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/uart_tx_engine_p.sv
// UART transmitter: FIFO-fed framing with runtime data length, parity, stop bits and break.
module uart_tx_engine_p
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int BAUD_W     = 19
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [3:0]                  dlen,
  input  logic                        pen,
  input  logic                        ohel,
  input  logic                        two_stop,
  input  logic                        brk,
  input  logic                        load,
  input  logic [DATA_W-1:0]           out_port,
  input  logic [BAUD_W-1:0]           k,
  output logic                        TxRdy,
  output logic                        Tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt,
  output logic                        ovf
);

  localparam logic [BAUD_W-1:0] K_ONE = 1;

  function automatic logic [BAUD_W-1:0] clamp_k(input logic [BAUD_W-1:0] kv);
    if (kv < BAUD_W'(K_MIN)) return BAUD_W'(K_MIN);
    return kv;
  endfunction

  function automatic logic [3:0] clamp_dlen(input logic [3:0] d);
    if (int'(d) < DLEN_MIN) return 4'(DLEN_MIN);
    if (int'(d) > DATA_W)   return 4'(DATA_W);
    return d;
  endfunction

  tx_state_t         state;
  logic [BAUD_W-1:0] cnt, k_q;
  logic [3:0]        bit_idx, dlen_q;
  logic              pen_q, two_q, par, mab;
  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] f_dout;
  logic              f_full, f_empty;
  logic              bit_end, last_stop, pop;

  uart_tx_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (load),
    .pop   (pop),
    .din   (out_port),
    .dout  (f_dout),
    .count (fifo_cnt),
    .full  (f_full),
    .empty (f_empty)
  );

  assign TxRdy     = !f_full;
  assign bit_end   = (cnt == k_q - K_ONE);
  assign last_stop = !two_q || (bit_idx == 4'd1);
  // Break waits for the line to be idle; a pending word never preempts it.
  assign pop = !f_empty && !brk &&
               ((state == ST_IDLE) || (state == ST_STOP && bit_end && last_stop));

  // Frame datapath: config snapshot at pop, shift register and parity accumulator.
  always_ff @(posedge clk) begin
    if (pop) begin
      sh     <= f_dout;
      dlen_q <= clamp_dlen(dlen);
      pen_q  <= pen;
      two_q  <= two_stop;
      k_q    <= clamp_k(k);
      par    <= (par_mode_t'(ohel) == PAR_ODD);
    end else begin
      if (state == ST_IDLE && brk) k_q <= clamp_k(k);
      if (state == ST_DATA && bit_end) begin
        sh  <= sh >> 1;
        par <= par ^ sh[0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ovf <= 1'b0;
    else      ovf <= load && f_full && !pop;
  end

  // Line FSM with bit timer; Tx and busy are registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      mab     <= 1'b0;
      Tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (brk) begin
            state <= ST_BREAK;
            mab   <= 1'b0;
            Tx    <= 1'b0;
            busy  <= 1'b1;
          end else if (!f_empty) begin
            state <= ST_START;
            Tx    <= 1'b0;
            busy  <= 1'b1;
          end
        end
        ST_START: begin
          if (bit_end) begin
            state   <= ST_DATA;
            cnt     <= '0;
            bit_idx <= '0;
            Tx      <= sh[0];
          end else cnt <= cnt + K_ONE;
        end
        ST_DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == dlen_q - 4'd1) begin
              bit_idx <= '0;
              if (pen_q) begin
                state <= ST_PARITY;
                Tx    <= par ^ sh[0];
              end else begin
                state <= ST_STOP;
                Tx    <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 4'd1;
              Tx      <= sh[1];
            end
          end else cnt <= cnt + K_ONE;
        end
        ST_PARITY: begin
          if (bit_end) begin
            state   <= ST_STOP;
            cnt     <= '0;
            bit_idx <= '0;
            Tx      <= 1'b1;
          end else cnt <= cnt + K_ONE;
        end
        ST_STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (!last_stop) bit_idx <= 4'd1;
            else if (pop) begin
              state <= ST_START;
              Tx    <= 1'b0;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else cnt <= cnt + K_ONE;
        end
        ST_BREAK: begin
          if (!mab) begin
            cnt <= '0;
            if (!brk) begin
              mab <= 1'b1;
              Tx  <= 1'b1;
            end
          end else if (bit_end) begin
            state <= ST_IDLE;
            mab   <= 1'b0;
            busy  <= 1'b0;
          end else cnt <= cnt + K_ONE;
        end
        default: begin
          state <= ST_IDLE;
          Tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_engine_p.sv
// Scoreboard bench for uart_tx_engine_p: expected frames queued at load, checked bit by bit on Tx.
module tb_uart_tx_engine_p;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int BAUD_W     = 19;
  localparam int CW         = $clog2(FIFO_DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        dlen;
  logic              pen, ohel, two_stop, brk, load;
  logic [DATA_W-1:0] out_port;
  logic [BAUD_W-1:0] k;
  logic              TxRdy, Tx, busy, ovf;
  logic [CW-1:0]     fifo_cnt;

  always #5 clk = ~clk;

  uart_tx_engine_p #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .BAUD_W(BAUD_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .dlen     (dlen),
    .pen      (pen),
    .ohel     (ohel),
    .two_stop (two_stop),
    .brk      (brk),
    .load     (load),
    .out_port (out_port),
    .k        (k),
    .TxRdy    (TxRdy),
    .Tx       (Tx),
    .busy     (busy),
    .fifo_cnt (fifo_cnt),
    .ovf      (ovf)
  );

  typedef struct {
    logic [15:0] bits;
    int          nbits;
    int          kk;
    int          cnt0;
  } frame_t;

  frame_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int last_wait;
  int fifo_exp [6] = '{1, 1, 2, 3, 4, 4};
  int start_cnt[5] = '{1, 3, 2, 1, 0};

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic frame_t model(input logic [7:0] w, input int dl, input bit p,
                                   input bit odd, input bit two, input int kv, input int c0);
    frame_t f;
    int n;
    bit pb;
    if (dl < 5) dl = 5;
    if (dl > DATA_W) dl = DATA_W;
    if (kv < 2) kv = 2;
    f.bits = '0;
    n = 1;
    pb = odd;
    for (int i = 0; i < dl; i++) begin
      f.bits[n] = w[i];
      pb ^= w[i];
      n++;
    end
    if (p) begin f.bits[n] = pb; n++; end
    f.bits[n] = 1'b1; n++;
    if (two) begin f.bits[n] = 1'b1; n++; end
    f.nbits = n;
    f.kk    = kv;
    f.cnt0  = c0;
    return f;
  endfunction

  task automatic push_frame(input logic [7:0] w, input int c0);
    sb.push_back(model(w, int'(dlen), pen, ohel, two_stop, int'(k), c0));
  endtask

  task automatic load_word(input logic [7:0] w, input int c0);
    @(negedge clk);
    out_port = w;
    load = 1'b1;
    push_frame(w, c0);
    @(negedge clk);
    load = 1'b0;
  endtask

  // Receives one frame; b2b demands the start bit on the very next cycle.
  task automatic rx_frame(input string tag, input bit b2b);
    frame_t f;
    int w;
    int bad_busy;
    int obs;
    w = 0;
    if (b2b) begin
      @(negedge clk);
      w = 1;
      chk({tag, "_gap"}, Tx, 0);
    end else begin
      do begin
        @(negedge clk);
        w++;
      end while (Tx !== 1'b0 && w < 20000);
      if (Tx !== 1'b0) begin
        chk({tag, "_timeout"}, Tx, 0);
        return;
      end
    end
    last_wait = w;
    if (sb.size() == 0) begin
      chk({tag, "_sbq"}, sb.size(), 1);
      return;
    end
    f = sb.pop_front();
    if (f.cnt0 >= 0) chk({tag, "_cnt"}, fifo_cnt, f.cnt0);
    bad_busy = 0;
    for (int i = 0; i < f.nbits; i++) begin
      obs = f.bits[i];
      for (int j = 0; j < f.kk; j++) begin
        if (i != 0 || j != 0) @(negedge clk);
        if (Tx !== f.bits[i]) obs = Tx;
        if (busy !== 1'b1) bad_busy++;
      end
      chk($sformatf("%s_bit%0d", tag, i), obs, f.bits[i]);
    end
    chk({tag, "_busy"}, bad_busy, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int w;
    rst = 1'b0; dlen = 4'd8; pen = 1'b0; ohel = 1'b0; two_stop = 1'b0;
    brk = 1'b0; load = 1'b0; out_port = '0; k = 19'd109;
    repeat (3) @(negedge clk);
    chk("rst_tx", Tx, 1);
    chk("rst_txrdy", TxRdy, 1);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", fifo_cnt, 0);
    chk("rst_ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b1;

    // 8N1, k=109
    load_word(8'hA5, 0);
    chk("8n1_cnt_e0", fifo_cnt, 1);
    chk("8n1_tx_e0", Tx, 1);
    rx_frame("8n1", 1'b0);
    chk("8n1_lat", last_wait, 1);
    @(negedge clk);
    chk("8n1_busy_end", busy, 0);
    chk("8n1_tx_end", Tx, 1);

    // 7 data bits with even then odd parity
    k = 19'd16; dlen = 4'd7; pen = 1'b1; ohel = 1'b0;
    load_word(8'hA5, 0);
    rx_frame("p7e", 1'b0);
    ohel = 1'b1;
    load_word(8'hA5, 0);
    rx_frame("p7o", 1'b0);

    // 8 bits, even parity, two stop bits
    k = 19'd109; dlen = 4'd8; pen = 1'b1; ohel = 1'b0; two_stop = 1'b1;
    load_word(8'hA5, 0);
    rx_frame("8e2", 1'b0);
    @(negedge clk);
    chk("8e2_busy_end", busy, 0);

    // FIFO fill, overflow on the sixth load, back-to-back drain
    k = 19'd8; pen = 1'b0; two_stop = 1'b0;
    fork
      begin
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
          out_port = 8'(8'h30 + i);
          load = 1'b1;
          if (i < 5) push_frame(8'(8'h30 + i), start_cnt[i]);
          @(negedge clk);
          chk($sformatf("fill_cnt%0d", i), fifo_cnt, fifo_exp[i]);
          chk($sformatf("fill_rdy%0d", i), TxRdy, int'(fifo_exp[i] != FIFO_DEPTH));
          chk($sformatf("fill_ovf%0d", i), ovf, int'(i == 5));
        end
        load = 1'b0;
        @(negedge clk);
        chk("ovf_clear", ovf, 0);
      end
      begin
        rx_frame("ff0", 1'b0);
        for (int i = 1; i < 5; i++) rx_frame($sformatf("ff%0d", i), 1'b1);
      end
    join
    @(negedge clk);
    chk("ff_busy_end", busy, 0);

    // Break requested mid-frame, with a word queued behind it
    load_word(8'h81, 0);
    fork
      rx_frame("brkA", 1'b0);
      begin
        repeat (30) @(negedge clk);
        brk = 1'b1;
        load_word(8'h5A, 0);
      end
    join
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (Tx !== 1'b0 && w < 10);
    chk("brk_low_lat", w, 2);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (Tx !== 1'b0 || busy !== 1'b1) bad++;
    end
    chk("brk_hold", bad, 0);
    brk = 1'b0;
    bad = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (Tx !== 1'b1) bad++;
    end
    chk("brk_mark", bad, 0);
    rx_frame("brkB", 1'b0);
    chk("brk_resume", int'(last_wait <= 2), 1);

    // Reset mid data bit
    k = 19'd16;
    load_word(8'h00, -1);
    load_word(8'h3C, -1);
    repeat (40) @(negedge clk);
    chk("pre_rst_tx", Tx, 0);
    chk("pre_rst_cnt", fifo_cnt, 1);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_tx", Tx, 1);
    chk("rst_mid_cnt", fifo_cnt, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_rdy", TxRdy, 1);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (Tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("rst_no_resume", bad, 0);

    // k clamped to 2
    dlen = 4'd8; pen = 1'b0; k = 19'd0;
    load_word(8'h3C, 0);
    rx_frame("k0", 1'b0);
    k = 19'd1;
    load_word(8'hC5, 0);
    rx_frame("k1", 1'b0);

    // dlen clamped low and high
    k = 19'd4; dlen = 4'd3;
    load_word(8'h6A, 0);
    rx_frame("dl3", 1'b0);
    dlen = 4'd12; pen = 1'b1;
    load_word(8'h96, 0);
    rx_frame("dl12", 1'b0);
    @(negedge clk);
    chk("end_busy", busy, 0);
    chk("end_tx", Tx, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_engine_p.md
# uart_tx_engine_p

Parametrised successor to the fixed-format UART transmit engine: serialises data words onto `Tx` with runtime-selectable data length, parity, and stop-bit count. Adds a small transmit FIFO, break generation, and overflow reporting. Sits between the processor output port (`out_port`/`load` strobe) and the serial pin, alongside the receive engine, and shares the baud count `k` with it.

## Interface
Parameters:
- `DATA_W`, 8: maximum data bits per frame; must be ≥5.
- `FIFO_DEPTH`, 4: transmit FIFO entries; power of 2, ≥2.
- `BAUD_W`, 19: width of the baud count `k`.

Ports:
- `clk`, in, 1: single system clock; all logic on its rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `dlen`, in, 4: data bits per frame. Values below 5 are treated as 5; values above `DATA_W` as `DATA_W`.
- `pen`, in, 1: parity enable.
- `ohel`, in, 1: parity select; 1 = odd, 0 = even.
- `two_stop`, in, 1: 1 selects two stop bits, 0 selects one.
- `brk`, in, 1: break request.
- `load`, in, 1: write strobe, one entry per cycle while high.
- `out_port`, in, `DATA_W`: word to enqueue on `load`.
- `k`, in, `BAUD_W`: clocks per bit. Values below 2 are treated as 2.
- `TxRdy`, out, 1: FIFO not full.
- `Tx`, out, 1: serial line; idles high.
- `busy`, out, 1: high while a frame or break is on the line.
- `fifo_cnt`, out, clog2(`FIFO_DEPTH`)+1: current FIFO occupancy.
- `ovf`, out, 1: one-cycle pulse when `load` arrives while the FIFO is full.

## Operation
- **FIFO.** `load` with `TxRdy`=1 enqueues `out_port`. `load` with FIFO full drops the word and pulses `ovf`. A simultaneous enqueue and dequeue leaves `fifo_cnt` unchanged and is legal even when full.
- **Config sampling.** The FSM latches `dlen`, `pen`, `ohel`, `two_stop`, and `k` at the moment it pops a word. Changes to these inputs mid-frame do not affect the current frame.
- **Frame format.** Start bit (0), then `dlen` data bits LSB first, then parity if `pen`, then 1 or 2 stop bits (1).
  - Even parity is the XOR of the transmitted data bits.
  - Odd parity is the inverse of even parity.
  - Upper data bits beyond `dlen` are ignored.
- **FSM states.** IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE → START: FIFO non-empty and `brk`=0.
  - IDLE → BREAK: `brk`=1; takes priority over a non-empty FIFO.
  - START → DATA after one bit period.
  - DATA → PARITY (if `pen`) or STOP after `dlen` bit periods.
  - PARITY → STOP after one bit period.
  - STOP → START directly (back-to-back, no idle gap) if the FIFO is non-empty and `brk`=0; otherwise STOP → IDLE.
  - BREAK: `Tx`=0 while `brk`=1. On `brk` falling, drive `Tx`=1 for one bit period (mark-after-break), then return to IDLE.
- **Break timing.** `brk` asserted mid-frame takes effect only after the current frame's final stop bit.
- **Bit timer.** Counts 0..k−1; the bit advances when the count reaches k−1. The timer is reset at every state entry.
- **Reset.** Asserting `rst` mid-frame aborts immediately: `Tx`=1, FIFO flushed. On deassertion, no partial frame is resumed.

## Timing
- **Reset values.** `Tx`=1, `TxRdy`=1, `busy`=0, `fifo_cnt`=0, `ovf`=0, FSM=IDLE.
- **Start latency.** With the FSM idle and the FIFO empty, if `load` is sampled at edge E0:
  - `fifo_cnt`=1 after E0.
  - The word is popped at E1.
  - `Tx` goes low and `busy` goes high after E1.
  - `fifo_cnt` returns to 0 after E1.
- **Bit period.** Exactly k clocks per bit.
- **Frame length.** (2 + dlen + pen + two_stop)·k clocks.
- **Output registers.** `Tx` is registered, with no combinational path from inputs. `TxRdy` and `fifo_cnt` reflect the registered FIFO state. `ovf` is registered, one cycle after the offending `load` edge.
- **End of frame.** `busy` falls on the edge that ends the last stop bit when the FSM goes to IDLE.

## Structure
- **Shared package `uart_pkg`:**
  - FSM state enum.
  - Min/max data length constants (5, `DATA_W`).
  - `k` minimum constant (2).
  - Parity-mode encodings shared with the receive engine.
- **Sub-module `uart_tx_fifo`:** synchronous FIFO parametrised by width and depth. It provides count, full, and empty, and supports same-cycle push/pop. The top level holds the FSM, bit timer, shift register, and parity accumulator.

## Test plan
- **8N1.** `out_port`=8'hA5, k=109, dlen=8, pen=0, two_stop=0, one `load`.
  - `Tx` sequence: 0,1,0,1,0,0,1,0,1,1, each bit 109 clocks.
  - Total frame 1090 clocks; `busy` falls after the stop bit.
- **7-bit parity.** `out_port`=8'hA5, dlen=7, pen=1.
  - `ohel`=0: parity bit 1.
  - `ohel`=1: parity bit 0.
  - Frame is 10 bits.
- **8-bit even parity, two stop bits.** dlen=8, pen=1, `ohel`=0, two_stop=1.
  - Parity bit 0; two stop bits; 12 bits total, 1308 clocks.
- **FIFO fill and back-to-back.** Five consecutive `load` cycles with `FIFO_DEPTH`=4 while idle.
  - `TxRdy` drops when the FIFO is full.
  - `ovf` pulses once only if the FIFO is full at the fifth `load`.
  - Frames go out back-to-back with no idle gap.
  - `fifo_cnt` decrements at each frame start.
- **Break.** `brk`=1 mid-frame.
  - The frame completes, then `Tx` is held low.
  - After `brk`=0: `Tx` high for k clocks, then the queued word starts.
- **Reset and clamping.**
  - `rst` low mid-data-bit: `Tx`=1 and `fifo_cnt`=0 immediately.
  - k=0 or 1: bit period is 2 clocks.
  - dlen=3: 5 data bits sent.
